// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: requester handshakes, UART strobe side and FIFO status of the TX scheduler
interface uart_tx_sched_if #(
    parameter int DEPTH = 16
);
    logic                     req0_valid;
    logic [7:0]               req0_data;
    logic                     req0_ready;
    logic                     req1_valid;
    logic [7:0]               req1_data;
    logic                     req1_ready;
    logic                     flush;
    logic                     uart_busy;
    logic                     uart_wr;
    logic [7:0]               uart_tx_data;
    logic [$clog2(DEPTH):0]   level;
    logic                     empty;
    logic                     full;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, flush, uart_busy,
        input  req0_ready, req1_ready, uart_wr, uart_tx_data, level, empty, full
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, flush, uart_busy,
        output req0_ready, req1_ready, uart_wr, uart_tx_data, level, empty, full
    );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin merge of two byte sources into a FIFO, drained into a UART with guarded strobes
module uart_tx_sched #(
    parameter int DEPTH = 16,
    parameter int GUARD = 2
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_sched_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = (GUARD > 2) ? $clog2(GUARD) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD, DRAIN} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [GW-1:0]   r_cnt;
    logic [GW-1:0]   w_next_cnt;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [LW-1:0]   r_level;
    logic [LW-1:0]   w_next_level;
    logic            r_empty;
    logic            r_full;
    logic            r_rr;
    logic            r_wr;
    logic [7:0]      r_tx_data;
    logic            w_both;
    logic            w_rdy0;
    logic            w_rdy1;
    logic            w_push0;
    logic            w_push1;
    logic            w_push;
    logic            w_wr_en;
    logic            w_pop;
    logic [7:0]      w_push_data;

    // Contention is resolved by r_rr (0 favours req0); a full FIFO refuses both, even if a pop is due
    assign w_both      = bus.req0_valid && bus.req1_valid;
    assign w_rdy0      = !r_full && !(w_both && r_rr);
    assign w_rdy1      = !r_full && !(w_both && !r_rr);
    assign w_push0     = bus.req0_valid && w_rdy0;
    assign w_push1     = bus.req1_valid && w_rdy1;
    assign w_push      = w_push0 || w_push1;
    assign w_push_data = w_push0 ? bus.req0_data : bus.req1_data;

    // A flush still completes the handshake but drops the byte; pops only start from IDLE
    assign w_wr_en      = w_push && !bus.flush;
    assign w_pop        = (r_state == IDLE) && !r_empty && !bus.uart_busy && !bus.flush;
    assign w_next_level = r_level + LW'(w_wr_en) - LW'(w_pop);

    assign bus.req0_ready   = w_rdy0;
    assign bus.req1_ready   = w_rdy1;
    assign bus.uart_wr      = r_wr;
    assign bus.uart_tx_data = r_tx_data;
    assign bus.level        = r_level;
    assign bus.empty        = r_empty;
    assign bus.full         = r_full;

    // Round-robin pointer moves only after a contended transfer that was actually stored
    always_ff @(posedge clk) begin
        if (reset)
            r_rr <= 1'b0;
        else if (w_both && w_push && !bus.flush)
            r_rr <= !r_rr;
    end

    // Storage array; no reset needed since occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (w_wr_en && !reset)
            r_mem[r_wptr] <= w_push_data;
    end

    // Pointers and registered occupancy flags, cleared by reset or flush
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            if (w_wr_en)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            r_level <= w_next_level;
            r_empty <= (w_next_level == '0);
            r_full  <= (w_next_level == LW'(DEPTH));
        end
    end

    // TX sequencer next state: strobe, ignore busy for the guard window, then wait for busy to drop
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            IDLE:  w_next_state = w_pop ? ISSUE : IDLE;
            ISSUE: begin
                w_next_state = HOLD;
                w_next_cnt   = GW'(GUARD - 1);
            end
            HOLD: begin
                w_next_state = (r_cnt <= GW'(1)) ? DRAIN : HOLD;
                w_next_cnt   = (r_cnt == '0) ? r_cnt : r_cnt - GW'(1);
            end
            DRAIN: w_next_state = bus.uart_busy ? DRAIN : IDLE;
        endcase
    end

    // Sequencer registers; the strobe is high exactly in the ISSUE cycle and the data holds until the next pop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_wr      <= 1'b0;
            r_tx_data <= 8'h00;
        end else if (bus.flush) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_wr    <= w_pop;
            if (w_pop)
                r_tx_data <= r_mem[r_rptr];
        end
    end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Transmit-side controller for the buart serial core.
- Arbitrates two byte requesters into a shared TX FIFO:
  - port 0: CPU memory-mapped data-register writes.
  - port 1: a hardware console/trace source.
- Sequences the UART by issuing single-cycle write strobes only when the UART is idle.
- Removes CPU busy-polling and protects against the busy-flag rise latency after a write.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2.
- GUARD, 2, cycles after a write strobe during which uart_busy is ignored and no new strobe is issued; ≥1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 (CPU) has a byte
- req0_data  in  8  requester 0 byte
- req0_ready  out  1  requester 0 byte accepted this cycle when valid&&ready
- req1_valid  in  1  requester 1 (trace) has a byte
- req1_data  in  8  requester 1 byte
- req1_ready  out  1  requester 1 accept
- flush  in  1  synchronous FIFO/sequencer clear (e.g. break detected)
- uart_busy  in  1  UART transmitter busy
- uart_wr  out  1  one-cycle write strobe to UART
- uart_tx_data  out  8  byte presented with uart_wr
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- empty  out  1  level==0
- full  out  1  level==DEPTH

Behaviour:
- Reset (sync, on clk edge with reset=1):
  - level=0, empty=1, full=0.
  - uart_wr=0, uart_tx_data=8'h00.
  - FSM=IDLE, round-robin pointer favours req0.
  - Reset has priority over flush and all other inputs.
- Arbitration (combinational ready):
  - Both ready outputs are 0 when full.
  - If only one requester is valid, its ready = !full.
  - If both are valid, the grant goes to the pointer side; the other's ready=0.
  - The pointer flips to the non-granted side after each two-way-contended accepted transfer only; uncontested grants leave it unchanged.
  - At most one push per cycle. Data is written at the tail on the clock edge.
  - ready does not depend on a same-cycle pop: no bypass when full.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - Push and pop in the same cycle: level unchanged, both pointers advance.
  - level, empty and full are registered.
- TX FSM states IDLE, ISSUE, HOLD, DRAIN:
  - IDLE: if !empty && !uart_busy, go to ISSUE at the next edge. On that same edge, uart_wr<=1, uart_tx_data<=head, pop head.
  - ISSUE (one cycle, uart_wr=1): next state HOLD; uart_wr<=0; guard counter<=GUARD-1.
  - HOLD: uart_busy is ignored. Counter decrements each cycle; at 0, go to DRAIN.
  - DRAIN: when uart_busy==0, go to IDLE.
  - uart_tx_data holds its value until the next ISSUE.
- Latency and throughput:
  - A byte accepted into an empty FIFO at edge t gives empty=0 after t. uart_wr is high in cycle t+1→t+2 (second edge after accept), provided the UART is idle.
  - Minimum spacing between uart_wr pulses is GUARD+2 cycles, plus however long busy stays high.
- Flush:
  - At the edge: level=0, pointers=0, FSM=IDLE, uart_wr<=0.
  - A push in a flush cycle is discarded, but its handshake still completes (ready as normal).
  - A flush during ISSUE does not retract the strobe already asserted this cycle.
  - The round-robin pointer is unchanged.
- Reset mid-transfer: the FIFO is cleared; any strobe in flight is dropped at the edge.

Test Plan:
- Reset, then req0 pushes 8'h41 at edge 1 with uart_busy=0 -> uart_wr=1 with uart_tx_data=8'h41 exactly in the cycle after edge 2; level returns to 0.
- req0 and req1 valid every cycle with distinct bytes (A0..,B0..), UART busy for 10 cycles after each strobe -> FIFO order alternates A0,B0,A1,B1,...; full asserts at level=16 with both readies 0; no byte lost or duplicated.
- Single strobe with uart_busy rising 2 cycles late (GUARD=2) -> no second uart_wr until busy has risen and fallen; pulse spacing ≥4 cycles.
- Fill to full, then offer a push in the same cycle as a pop -> push refused (ready=0); level goes 16→15 at that edge.
- Level 5 with flush asserted alongside req1 valid -> level=0, empty=1 next cycle; pushed byte never transmitted; no uart_wr afterwards.
- Pointer wrap: push and transmit 40 bytes with an incrementing pattern -> output sequence matches input exactly across the wrap.
